// File: rtl/lca_iter_adder_if.sv
// Operand/result handshake bundle for the iterative lookahead adder.
// The master modport is the side that supplies operands and consumes results.
interface lca_iter_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             C_1;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             CO;
    logic             OV;

    modport master (
        output in_valid, A_in, B_in, C_1, sub, out_ready,
        input  in_ready, out_valid, S, CO, OV
    );

    modport slave (
        input  in_valid, A_in, B_in, C_1, sub, out_ready,
        output in_ready, out_valid, S, CO, OV
    );
endinterface

// File: rtl/lca_iter_adder.sv
// Multi-cycle carry-lookahead adder/subtractor: one BLK-bit lookahead block
// per clock, with the block carry registered between blocks.
module lca_iter_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input logic          clk,
    input logic          rst_n,
    lca_iter_adder_if.slave bus
);
    localparam int NBLK = WIDTH / BLK;
    localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;

    if ((BLK < 1) || (WIDTH % BLK != 0)) begin : g_bad_param
        $error("lca_iter_adder: WIDTH must be a positive multiple of BLK");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;   // operand A, shifted down so the active block sits at [BLK-1:0]
    logic [WIDTH-1:0] b_r;   // effective operand B, shifted the same way
    logic             c_r;   // carry into the active block
    logic [WIDTH-1:0] s_r;
    logic             co_r;
    logic             ov_r;

    logic [BLK-1:0]   g;
    logic [BLK-1:0]   p;
    logic [BLK:0]     c;
    logic [BLK-1:0]   sum;

    // Lookahead for the active block: every carry is expanded directly from
    // G/P and the block carry-in, so no carry ripples bit to bit.
    always_comb begin
        logic cc;
        logic pp;
        cc   = 1'b0;
        pp   = 1'b0;
        g    = a_r[BLK-1:0] & b_r[BLK-1:0];
        p    = a_r[BLK-1:0] ^ b_r[BLK-1:0];
        c    = '0;
        c[0] = c_r;
        for (int i = 0; i < BLK; i++) begin
            cc = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & c_r);
        end
        sum = p ^ c[BLK-1:0];
    end

    // Control FSM and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= 1'b0;
            s_r   <= '0;
            co_r  <= 1'b0;
            ov_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + ~borrow.
                        a_r   <= bus.A_in;
                        b_r   <= bus.sub ? ~bus.B_in : bus.B_in;
                        c_r   <= bus.C_1 ^ bus.sub;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a_r <= a_r >> BLK;
                    b_r <= b_r >> BLK;
                    c_r <= c[BLK];
                    // Only the active block's S bits change; the rest hold.
                    for (int k = 0; k < NBLK; k++) begin
                        if (cnt == CW'(k)) s_r[k*BLK +: BLK] <= sum;
                    end
                    if (cnt == CW'(NBLK - 1)) begin
                        co_r  <= c[BLK];
                        ov_r  <= c[BLK] ^ c[BLK-1];
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.S         = s_r;
    assign bus.CO        = co_r;
    assign bus.OV        = ov_r;
endmodule

// File: tb/tb_lca_iter_adder.sv
// Bench for lca_iter_adder: 16/4 main instance with a scoreboard monitor,
// plus 4/4 and 32/8 instances exercised with directed operations.
module tb_lca_iter_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    lca_iter_adder_if #(.WIDTH(16)) bus16();
    lca_iter_adder_if #(.WIDTH(4))  bus4();
    lca_iter_adder_if #(.WIDTH(32)) bus32();

    lca_iter_adder #(.WIDTH(16), .BLK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    lca_iter_adder #(.WIDTH(4),  .BLK(4)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    lca_iter_adder #(.WIDTH(32), .BLK(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic from the integer definition of add/sub.
    function automatic void model(input int w, input longint a, input longint b,
                                  input logic c, input logic sb,
                                  output logic [31:0] s, output logic co, output logic ov);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint sa   = (a >= half) ? a - (m + 1) : a;
        longint sbv  = (b >= half) ? b - (m + 1) : b;
        longint cc   = longint'(c);
        longint u;
        longint r;
        if (!sb) begin
            u  = a + b + cc;
            co = (u > m);
            r  = sa + sbv + cc;
        end else begin
            u  = a - b - cc;
            co = (a >= b + cc);
            r  = sa - sbv - cc;
        end
        s  = 32'(u & m);
        ov = (r >= half) || (r < -half);
    endfunction

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          acc;
    } exp_t;

    exp_t q[$];
    bit   prev_ov;

    // Scoreboard monitor for the 16-bit instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_ov = 1'b0;
        end else begin
            chk("in_ready16", 64'(bus16.in_ready), 64'(q.size() == 0));
            if (bus16.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid16", 64'(bus16.out_valid), 64'd0);
                end else begin
                    chk("S16", 64'(bus16.S), 64'(q[0].s[15:0]));
                    chk("CO16", 64'(bus16.CO), 64'(q[0].co));
                    chk("OV16", 64'(bus16.OV), 64'(q[0].ov));
                    if (!prev_ov) chk("latency16", 64'(cyc), 64'(q[0].acc + 4));
                    if (bus16.out_ready) void'(q.pop_front());
                end
            end
            if (bus16.in_valid && bus16.in_ready) begin
                exp_t e;
                model(16, longint'(bus16.A_in), longint'(bus16.B_in), bus16.C_1, bus16.sub,
                      e.s, e.co, e.ov);
                e.acc = cyc + 1;
                q.push_back(e);
            end
            prev_ov = bus16.out_valid;
        end
    end

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sb,
                        input logic [15:0] es, input logic eco, input logic eov, input string nm,
                        input int hold = 0, input bit toggle = 0);
        int n = 0;
        logic [15:0] s0;
        chk({nm, "_in_ready"}, 64'(bus16.in_ready), 64'd1);
        bus16.A_in = a; bus16.B_in = b; bus16.C_1 = c; bus16.sub = sb; bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        while (!bus16.out_valid && n < 20) begin
            if (toggle) begin
                bus16.A_in = ~bus16.A_in;
                bus16.in_valid = ~bus16.in_valid;
            end
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, 64'(n), 64'd4);
        chk({nm, "_S"}, 64'(bus16.S), 64'(es));
        chk({nm, "_CO"}, 64'(bus16.CO), 64'(eco));
        chk({nm, "_OV"}, 64'(bus16.OV), 64'(eov));
        s0 = bus16.S;
        for (int h = 0; h < hold; h++) begin
            if (toggle) bus16.in_valid = 1'b1;
            @(posedge clk); #1;
            chk({nm, "_hold_S"}, 64'(bus16.S), 64'(s0));
            chk({nm, "_hold_valid"}, 64'(bus16.out_valid), 64'd1);
            chk({nm, "_hold_in_ready"}, 64'(bus16.in_ready), 64'd0);
        end
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        chk({nm, "_ready_after"}, 64'(bus16.in_ready), 64'd1);
    endtask

    // Directed operation on the 4-bit (w=4) or 32-bit (w=32) instance.
    task automatic op_var(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] es, input logic eco, input logic eov, input string nm);
        int n = 0;
        logic [31:0] ms;
        logic mco, mov;
        logic vld;
        logic [31:0] s_act;
        logic co_act, ov_act;
        if (w == 4) begin
            bus4.A_in = a[3:0]; bus4.B_in = b[3:0]; bus4.C_1 = c; bus4.sub = 1'b0; bus4.in_valid = 1'b1;
        end else begin
            bus32.A_in = a; bus32.B_in = b; bus32.C_1 = c; bus32.sub = 1'b0; bus32.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0; bus32.in_valid = 1'b0;
        vld = (w == 4) ? bus4.out_valid : bus32.out_valid;
        while (!vld && n < 20) begin
            @(posedge clk); #1;
            n++;
            vld = (w == 4) ? bus4.out_valid : bus32.out_valid;
        end
        s_act  = (w == 4) ? 32'(bus4.S) : bus32.S;
        co_act = (w == 4) ? bus4.CO : bus32.CO;
        ov_act = (w == 4) ? bus4.OV : bus32.OV;
        model(w, longint'(a), longint'(b), c, 1'b0, ms, mco, mov);
        chk({nm, "_lat"}, 64'(n), (w == 4) ? 64'd1 : 64'd4);
        chk({nm, "_S"}, 64'(s_act), 64'(es));
        chk({nm, "_CO"}, 64'(co_act), 64'(eco));
        chk({nm, "_OV"}, 64'(ov_act), 64'(eov));
        chk({nm, "_S_model"}, 64'(s_act), 64'(ms));
        bus4.out_ready = 1'b1; bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0; bus32.out_ready = 1'b0;
        chk({nm, "_ready_after"}, (w == 4) ? 64'(bus4.in_ready) : 64'(bus32.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ms;
        logic mco, mov;
        {bus16.in_valid, bus16.A_in, bus16.B_in, bus16.C_1, bus16.sub, bus16.out_ready} = '0;
        {bus4.in_valid, bus4.A_in, bus4.B_in, bus4.C_1, bus4.sub, bus4.out_ready} = '0;
        {bus32.in_valid, bus32.A_in, bus32.B_in, bus32.C_1, bus32.sub, bus32.out_ready} = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_S", 64'(bus16.S), 64'd0);
        chk("rst_CO", 64'(bus16.CO), 64'd0);
        chk("rst_OV", 64'(bus16.OV), 64'd0);
        chk("rst_out_valid", 64'(bus16.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus16.in_ready), 64'd1);

        // Pin the reference model to hand-computed values.
        model(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0, ms, mco, mov);
        chk("model_ovf_add", {31'd0, mco, mov, ms}, {31'd0, 1'b0, 1'b1, 32'h8000});
        model(16, 64'h0005, 64'h0007, 1'b1, 1'b1, ms, mco, mov);
        chk("model_sub_borrow", {31'd0, mco, mov, ms}, {31'd0, 1'b0, 1'b0, 32'hFFFD});

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        op16(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "chain_b");
        op16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "chain_c");
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
        op16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");
        op16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_b0");
        op16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, "sub_b1");
        op16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "bp", 5, 1'b1);
        op16(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, "after_bp");

        // Reset during the second CALC cycle.
        bus16.A_in = 16'h1234; bus16.B_in = 16'h1111; bus16.C_1 = 1'b0; bus16.sub = 1'b0;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_S", 64'(bus16.S), 64'd0);
        chk("midrst_CO", 64'(bus16.CO), 64'd0);
        chk("midrst_OV", 64'(bus16.OV), 64'd0);
        chk("midrst_out_valid", 64'(bus16.out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(bus16.in_ready), 64'd1);
        @(posedge clk); #1;
        op16(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "post_rst");

        op_var(4, 32'hF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, "w4_b");
        op_var(4, 32'hF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, "w4_c");
        op_var(4, 32'h7, 32'h1, 1'b0, 32'h8, 1'b0, 1'b1, "w4_ovf");
        op_var(32, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, "w32_b");
        op_var(32, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, "w32_c");
        op_var(32, 32'h12345678, 32'h0FEDCBA9, 1'b1, 32'h22222222, 1'b0, 1'b0, "w32_mix");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
